output_buffer_drain: RTL and testbench
======================================

Name: output_buffer_drain

Overview:
Downstream neighbour of the accumulator stage. Captures each finished 32-bit result the accumulator emits on its store interface into a 16-entry addressed result buffer. On request, streams every occupied entry to the host/readout path in ascending address order over a valid/ready handshake. Tracks occupancy and flags results that are overwritten before being drained.

Parameters:
DEPTH, 16, number of result entries (power of two)
ADDR_W, 4, entry address width, log2(DEPTH)
DATA_W, 32, result word width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
output_data  input  DATA_W  result word from accumulator
output_buffer_addr  input  ADDR_W  target entry for output_data
output_buffer_enable  input  1  write strobe, one entry per cycle
drain_start  input  1  pulse: begin streaming occupied entries
clear  input  1  pulse: invalidate all entries and clear overwrite_err (IDLE only)
out_valid  output  1  beat presented
out_ready  input  1  consumer accepts beat
out_data  output  DATA_W  beat payload
out_addr  output  ADDR_W  entry index of beat
out_last  output  1  final beat of this drain
busy  output  1  drain in progress (state DRAIN or out_valid)
drain_done  output  1  one-cycle pulse at end of drain
count  output  ADDR_W+1  number of valid entries
overwrite_err  output  1  sticky: a valid, undrained entry was overwritten

Behaviour:
- Reset: valid mask 0, state IDLE, out_valid/out_last/busy/drain_done/overwrite_err 0, out_data/out_addr 0, count 0. Storage array needs no reset. Reset mid-drain aborts the drain immediately; no further beats are produced.
- Write: when output_buffer_enable=1, mem[addr]<=data and valid[addr]<=1. Writes are accepted in every state. A write to an entry that is already valid sets overwrite_err, and the new data replaces the old.
- Writes become visible to the drain search from the next cycle.
- count is the registered popcount of the valid mask, updated the cycle after any write, load or clear.
- FSM states: IDLE and DRAIN.
  - IDLE: drain_start -> DRAIN, ptr<=0. clear invalidates all entries and clears overwrite_err. If clear and drain_start are both asserted, clear wins and drain_start is ignored.
  - DRAIN: drain_start and clear are ignored.
- Search step: performed in DRAIN at every edge where out_valid=0, or where out_valid&out_ready (handshake).
  - It finds the lowest valid index idx >= ptr.
  - If found: load out_data<=mem[idx], out_addr<=idx, out_valid<=1, ptr<=idx+1, valid[idx]<=0. Set out_last<=1 if no valid entry exists above idx.
  - If not found, or on the handshake of a beat with out_last=1: state<=IDLE, out_valid<=0, and drain_done pulses high for the following cycle.
- Latency: drain_start sampled at edge T puts DRAIN in effect at T+1; the first beat is presented after edge T+1. With out_ready held high, beats occur back-to-back, one per cycle.
- Empty buffer: busy is high for one cycle, drain_done pulses on the next cycle, and out_valid never asserts.
- Handshake rules: while out_valid=1 and out_ready=0, out_data, out_addr and out_last are held stable. out_valid never drops without a handshake, except on rst.
- Same-edge write and load to the same index: the loaded beat carries the old data. The write wins, so the entry stays valid with the new data for the next drain. overwrite_err is not set.
- A write to an index < ptr during a drain stays valid for the next drain.

Decomposition:
- Shared package: DEPTH/ADDR_W/DATA_W constants and the FSM state enum {IDLE, DRAIN}.
- One sub-module, next_valid_finder: combinational. Inputs are the valid mask and ptr. Outputs are found, idx (lowest set bit >= ptr) and any_above(idx).

Test Plan:
- Write 3=0x11, 7=0x22, 12=0x33; drain_start, out_ready=1 -> beats (3,0x11), (7,0x22), (12,0x33,last) on consecutive cycles from T+2; drain_done one cycle after the last handshake; count goes 3->0.
- Same setup, out_ready low for 5 cycles on the first beat -> out_valid, out_data=0x11 and out_addr=3 stable throughout; then remaining beats resume back-to-back.
- Write 5=0xA then 5=0xB before draining -> overwrite_err=1 and the drained beat is (5,0xB); clear in IDLE -> overwrite_err=0, count=0.
- drain_start with empty buffer -> busy high one cycle, drain_done at T+2, no out_valid.
- Entries 2 and 9 valid; while beat 2 is held (out_ready=0), write 6=0xAA and 1=0xBB -> beats 2, 6, 9(last); afterwards count=1 (entry 1 remains).
- rst asserted while a beat is held -> next cycle all outputs 0, count=0; a subsequent drain_start produces an empty drain.

Source files
------------

// File: rtl/output_buffer_drain_pkg.sv
// Shared constants, FSM state type and a popcount helper for the output buffer drain block.
package output_buffer_drain_pkg;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int PTR_W  = ADDR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic logic [PTR_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [PTR_W-1:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{(PTR_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/output_buffer_drain_next_valid_finder.sv
// Combinational search: lowest valid index at or above ptr, and whether any valid entry lies above it.
module output_buffer_drain_next_valid_finder
    import output_buffer_drain_pkg::*;
(
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic              found_o,
    output logic [ADDR_W-1:0] idx_o,
    output logic              any_above_o
);

    logic              hit;
    logic [ADDR_W-1:0] hit_idx;
    logic              more;

    // Every valid bit at or above ptr after the first hit is, by construction, above idx.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        more    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_i[i] && (PTR_W'(i) >= ptr_i)) begin
                if (!hit) begin
                    hit     = 1'b1;
                    hit_idx = ADDR_W'(i);
                end else begin
                    more = 1'b1;
                end
            end
        end
    end

    assign found_o     = hit;
    assign idx_o       = hit_idx;
    assign any_above_o = more;

endmodule

// File: rtl/output_buffer_drain.sv
// 16-entry addressed result buffer; drains occupied entries in ascending address order over valid/ready.
module output_buffer_drain
    import output_buffer_drain_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] output_data,
    input  logic [ADDR_W-1:0] output_buffer_addr,
    input  logic              output_buffer_enable,
    input  logic              drain_start,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              drain_done,
    output logic [ADDR_W:0]   count,
    output logic              overwrite_err
);

    // Handshake: a beat transfers on a rising edge where out_valid and out_ready are both high;
    // while out_valid is high and out_ready low, payload, address and last stay frozen.

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic [PTR_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    logic              found;
    logic [ADDR_W-1:0] idx;
    logic              any_above;
    logic              search;
    logic              load;
    logic              clear_act;

    output_buffer_drain_next_valid_finder u_finder (
        .valid_i     (valid_q),
        .ptr_i       (ptr_q),
        .found_o     (found),
        .idx_o       (idx),
        .any_above_o (any_above)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        valid_d     = valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        err_d       = err_q;
        load        = 1'b0;

        search    = (state_q == DRAIN) && (!out_valid_q || out_ready);
        clear_act = (state_q == IDLE) && clear;

        if (search) begin
            if ((out_valid_q && out_last_q) || !found) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                done_d      = 1'b1;
            end else begin
                load        = 1'b1;
                out_data_d  = mem[idx];
                out_addr_d  = idx;
                out_valid_d = 1'b1;
                out_last_d  = !any_above;
                ptr_d       = {1'b0, idx} + PTR_W'(1);
                valid_d[idx] = 1'b0;
            end
        end

        if (clear_act) begin
            valid_d = '0;
            err_d   = 1'b0;
        end else if ((state_q == IDLE) && drain_start) begin
            state_d = DRAIN;
            ptr_d   = '0;
        end

        // A write racing a load or a clear of the same entry is a fresh fill, not an overwrite.
        if (output_buffer_enable) begin
            if (valid_q[output_buffer_addr] && !clear_act &&
                !(load && (idx == output_buffer_addr))) begin
                err_d = 1'b1;
            end
            valid_d[output_buffer_addr] = 1'b1;
        end

        count_d = popcount(valid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (output_buffer_enable) begin
            mem[output_buffer_addr] <= output_data;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_addr      = out_addr_q;
    assign out_last      = out_last_q;
    assign busy          = (state_q == DRAIN) || out_valid_q;
    assign drain_done    = done_q;
    assign count         = count_q;
    assign overwrite_err = err_q;

endmodule

// File: tb/tb_output_buffer_drain.sv
// Bench for output_buffer_drain: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model of the buffer.
module tb_output_buffer_drain;
    import output_buffer_drain_pkg::*;

    localparam int BW = 1 + ADDR_W + DATA_W;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] output_data;
    logic [ADDR_W-1:0] output_buffer_addr;
    logic              output_buffer_enable;
    logic              drain_start;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              busy;
    logic              drain_done;
    logic [ADDR_W:0]   count;
    logic              overwrite_err;

    output_buffer_drain dut (
        .clk                  (clk),
        .rst                  (rst),
        .output_data          (output_data),
        .output_buffer_addr   (output_buffer_addr),
        .output_buffer_enable (output_buffer_enable),
        .drain_start          (drain_start),
        .clear                (clear),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_data             (out_data),
        .out_addr             (out_addr),
        .out_last             (out_last),
        .busy                 (busy),
        .drain_done           (drain_done),
        .count                (count),
        .overwrite_err        (overwrite_err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_valid [DEPTH];
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit              m_drain;
    int              m_ptr;
    bit              m_ov;
    logic [DATA_W-1:0] m_od;
    int              m_oa;
    bit              m_ol;
    bit              m_done;
    bit              m_err;
    int              m_count;

    task automatic model_step();
        bit was_idle;
        int hit;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            m_drain = 0; m_ptr = 0; m_ov = 0; m_od = '0; m_oa = 0;
            m_ol = 0; m_done = 0; m_err = 0; m_count = 0;
            return;
        end
        was_idle = !m_drain;
        m_done = 0;
        if (m_drain && (!m_ov || out_ready)) begin
            hit = -1;
            if (!(m_ov && m_ol)) begin
                for (int i = m_ptr; i < DEPTH; i++) begin
                    if (m_valid[i] && hit < 0) hit = i;
                end
            end
            if (hit < 0) begin
                m_drain = 0; m_ov = 0; m_ol = 0; m_done = 1;
            end else begin
                m_od = m_mem[hit];
                m_oa = hit;
                m_ov = 1;
                m_ol = 1;
                for (int j = hit + 1; j < DEPTH; j++) begin
                    if (m_valid[j]) m_ol = 0;
                end
                m_ptr = hit + 1;
                m_valid[hit] = 0;
            end
        end
        if (was_idle && clear) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            m_err = 0;
        end else if (was_idle && drain_start) begin
            m_drain = 1;
            m_ptr = 0;
        end
        if (output_buffer_enable) begin
            if (m_valid[output_buffer_addr]) m_err = 1;
            m_mem[output_buffer_addr] = output_data;
            m_valid[output_buffer_addr] = 1;
        end
        m_count = 0;
        for (int i = 0; i < DEPTH; i++) m_count += int'(m_valid[i]);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("out_valid", 64'(out_valid), 64'(m_ov));
            check("busy", 64'(busy), 64'(m_drain || m_ov));
            check("drain_done", 64'(drain_done), 64'(m_done));
            check("count", 64'(count), 64'(m_count));
            check("overwrite_err", 64'(overwrite_err), 64'(m_err));
            check("out_last", 64'(out_last), 64'(m_ol));
            if (m_ov) begin
                check("out_data", 64'(out_data), 64'(m_od));
                check("out_addr", 64'(out_addr), 64'(m_oa));
            end
        end
    end

    // ---------------- handshake monitor ----------------
    logic [BW-1:0] got_q [$];
    int            got_cyc_q [$];
    logic [BW-1:0] exp_q [$];
    int            cyc = 0;
    int            done_cyc = -1;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst && out_valid && out_ready) begin
                got_q.push_back({out_last, out_addr, out_data});
                got_cyc_q.push_back(cyc);
            end
            if (!rst && drain_done) done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        output_buffer_enable = 1'b1;
        output_buffer_addr   = ADDR_W'(a);
        output_data          = d;
        step();
        output_buffer_enable = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        got_q.delete();
        got_cyc_q.delete();
        done_cyc = -1;
    endtask

    task automatic start_drain(output int t0);
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < budget) begin
            step();
            if (drain_done) seen = 1;
            n++;
        end
        check("drain_done_within_budget", 64'(seen), 64'd1);
        step();
    endtask

    task automatic check_beats(input string name);
        logic [BW-1:0] g, e;
        check({name, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check(name, 64'(g), 64'(e));
        end
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        rst = 1'b1;
        output_data = '0;
        output_buffer_addr = '0;
        output_buffer_enable = 1'b0;
        drain_start = 1'b0;
        clear = 1'b0;
        out_ready = 1'b0;

        do_reset();
        check("reset_count", 64'(count), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // Basic back-to-back drain
        wr(3, 32'h11); wr(7, 32'h22); wr(12, 32'h33);
        check("t1_count_before", 64'(count), 64'd3);
        out_ready = 1'b1;
        start_drain(t0);
        wait_done(20);
        if (got_cyc_q.size() == 3) begin
            check("t1_first_beat_cycle", 64'(got_cyc_q[0]), 64'(t0 + 2));
            check("t1_last_beat_cycle", 64'(got_cyc_q[2]), 64'(t0 + 4));
            check("t1_done_cycle", 64'(done_cyc), 64'(got_cyc_q[2] + 1));
        end
        exp_q.push_back({1'b0, 4'd3, 32'h11});
        exp_q.push_back({1'b0, 4'd7, 32'h22});
        exp_q.push_back({1'b1, 4'd12, 32'h33});
        check_beats("t1");
        check("t1_count_after", 64'(count), 64'd0);

        // Back-pressure on the first beat
        wr(3, 32'h11); wr(7, 32'h22); wr(12, 32'h33);
        out_ready = 1'b0;
        start_drain(t0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 64'(out_valid), 64'd1);
            check("t2_hold_data", 64'(out_data), 64'h11);
            check("t2_hold_addr", 64'(out_addr), 64'd3);
            step();
        end
        out_ready = 1'b1;
        wait_done(20);
        if (got_cyc_q.size() == 3) begin
            check("t2_b2b_1", 64'(got_cyc_q[1]), 64'(got_cyc_q[0] + 1));
            check("t2_b2b_2", 64'(got_cyc_q[2]), 64'(got_cyc_q[1] + 1));
        end
        exp_q.push_back({1'b0, 4'd3, 32'h11});
        exp_q.push_back({1'b0, 4'd7, 32'h22});
        exp_q.push_back({1'b1, 4'd12, 32'h33});
        check_beats("t2");

        // Overwrite before drain, then clear
        wr(5, 32'hA);
        check("t3_err_first_write", 64'(overwrite_err), 64'd0);
        wr(5, 32'hB);
        check("t3_err_overwrite", 64'(overwrite_err), 64'd1);
        start_drain(t0);
        wait_done(20);
        exp_q.push_back({1'b1, 4'd5, 32'hB});
        check_beats("t3");
        check("t3_err_sticky", 64'(overwrite_err), 64'd1);
        wr(8, 32'h1);
        check("t3_count_pre_clear", 64'(count), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        check("t3_err_cleared", 64'(overwrite_err), 64'd0);
        check("t3_count_cleared", 64'(count), 64'd0);

        // Empty drain
        done_cyc = -1;
        start_drain(t0);
        check("t4_busy", 64'(busy), 64'd1);
        check("t4_no_valid", 64'(out_valid), 64'd0);
        wait_done(10);
        check("t4_done_cycle", 64'(done_cyc), 64'(t0 + 2));
        check("t4_busy_after", 64'(busy), 64'd0);
        check_beats("t4");

        // Writes during a held beat
        wr(2, 32'h2); wr(9, 32'h9);
        out_ready = 1'b0;
        start_drain(t0);
        step();
        wr(6, 32'hAA);
        wr(1, 32'hBB);
        out_ready = 1'b1;
        wait_done(20);
        exp_q.push_back({1'b0, 4'd2, 32'h2});
        exp_q.push_back({1'b0, 4'd6, 32'hAA});
        exp_q.push_back({1'b1, 4'd9, 32'h9});
        check_beats("t5");
        check("t5_count_after", 64'(count), 64'd1);

        // Reset while a beat is held
        wr(4, 32'h44); wr(10, 32'h1010);
        out_ready = 1'b0;
        start_drain(t0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_data", 64'(out_data), 64'd0);
        check("t6_addr", 64'(out_addr), 64'd0);
        check("t6_last", 64'(out_last), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(drain_done), 64'd0);
        check("t6_count", 64'(count), 64'd0);
        check("t6_err", 64'(overwrite_err), 64'd0);
        got_q.delete();
        got_cyc_q.delete();
        done_cyc = -1;
        out_ready = 1'b1;
        start_drain(t0);
        wait_done(10);
        check("t6_empty_done_cycle", 64'(done_cyc), 64'(t0 + 2));
        check_beats("t6");

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            rst                  = ($urandom_range(0, 999) < 4);
            output_buffer_enable = ($urandom_range(0, 99) < 40);
            output_buffer_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
            output_data          = $urandom;
            drain_start          = ($urandom_range(0, 99) < 10);
            clear                = ($urandom_range(0, 99) < 3);
            out_ready            = ($urandom_range(0, 99) < 60);
            step();
        end
        rst = 1'b0;
        output_buffer_enable = 1'b0;
        drain_start = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 40; n++) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
